// File: rtl/ft60x_tx_arb_if.sv
// ft60x_tx_arb_if: channel request bundle plus the FT60x inport stream seen by the Tx arbiter
interface ft60x_tx_arb_if #(parameter int NUM_CH = 4);
  logic [NUM_CH-1:0]    req_valid_i;
  logic [16*NUM_CH-1:0] req_data_i;
  logic [NUM_CH-1:0]    req_last_i;
  logic [NUM_CH-1:0]    req_accept_o;
  logic                 outport_valid_o;
  logic [15:0]          outport_data_o;
  logic                 outport_accept_i;
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, outport_accept_i,
    output req_accept_o, outport_valid_o, outport_data_o
  );
  modport master (
    output req_valid_i, req_data_i, req_last_i, outport_accept_i,
    input  req_accept_o, outport_valid_o, outport_data_o
  );
endinterface

// File: rtl/ft60x_tx_arb.sv
// ft60x_tx_arb: round-robin framing arbiter for the FT60x Tx inport (header, payload, trailer).
// FT60X_ARB_PRIO_EN: channel 0 wins arbitration whenever it requests.
module ft60x_tx_arb #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 256
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ft60x_tx_arb_if.slave  bus,
  output logic [1:0]     grant_o,
  output logic           busy_o
);
  typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;
  state_t      state_q;
  logic [1:0]  rr_q, grant_q, pick, rr_d;
  logic [10:0] count_q, count_d;
  logic        eop_q, xfer, cur_last;
  assign cur_last = bus.req_last_i[grant_q];
  assign xfer     = bus.outport_valid_o & bus.outport_accept_i;
  assign count_d  = count_q + 11'd1;
  assign rr_d     = (grant_q == 2'(NUM_CH - 1)) ? 2'd0 : grant_q + 2'd1;
  always_comb begin
    pick = rr_q;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (bus.req_valid_i[(int'(rr_q) + k) % NUM_CH]) pick = 2'((int'(rr_q) + k) % NUM_CH);
`ifdef FT60X_ARB_PRIO_EN
    if (bus.req_valid_i[0]) pick = 2'd0;
`endif
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      count_q <= '0;
      eop_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|bus.req_valid_i) begin
          grant_q <= pick;
          state_q <= HDR;
        end
        HDR: if (bus.outport_accept_i) state_q <= DATA;
        DATA: if (xfer) begin
          count_q <= count_d;
          if (cur_last || count_d == 11'(MAX_BURST)) begin
            eop_q   <= cur_last;
            state_q <= TRL;
          end
        end
        default: if (bus.outport_accept_i) begin
          state_q <= IDLE;
          count_q <= '0;
`ifdef FT60X_ARB_PRIO_EN
          if (grant_q != 2'd0) rr_q <= rr_d;
`else
          rr_q <= rr_d;
`endif
        end
      endcase
    end
  end
  // DATA is a pass-through of the granted channel; header/trailer come from registered state
  assign bus.outport_valid_o = (state_q == HDR) | (state_q == TRL) |
                               ((state_q == DATA) & bus.req_valid_i[grant_q]);
  assign bus.outport_data_o  = (state_q == HDR)  ? {4'hA, 2'b00, grant_q, 8'h00} :
                               (state_q == DATA) ? bus.req_data_i[16*grant_q +: 16] :
                               (state_q == TRL)  ? {4'h5, eop_q, count_q} : 16'h0000;
  assign bus.req_accept_o    = (state_q == DATA) ? NUM_CH'(bus.outport_accept_i) << grant_q : '0;
  assign grant_o = grant_q;
  assign busy_o  = state_q != IDLE;
endmodule

// File: tb/tb_ft60x_tx_arb.sv
// tb_ft60x_tx_arb: directed bench for ft60x_tx_arb (MAX_BURST=4), expectations adapt to FT60X_ARB_PRIO_EN
module tb_ft60x_tx_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] grant;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [16:0] chq[4][$];
  logic [15:0] outq[$];
  logic [15:0] e[$];
  logic [3:0] cont = 4'b0;
  bit toggle = 1'b0;
  bit acc_bad = 1'b0;
  ft60x_tx_arb_if #(.NUM_CH(4)) bus();
  ft60x_tx_arb #(.NUM_CH(4), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave), .grant_o(grant), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic drive();
    for (int n = 0; n < 4; n++) begin
      bus.req_valid_i[n]        = chq[n].size() > 0;
      bus.req_last_i[n]         = chq[n].size() > 0 ? chq[n][0][16] : 1'b0;
      bus.req_data_i[16*n +: 16] = chq[n].size() > 0 ? chq[n][0][15:0] : 16'h0;
    end
  endtask
  task automatic tick();
    logic [3:0] pop;
    @(negedge clk);
    if (bus.outport_valid_o && bus.outport_accept_i) outq.push_back(bus.outport_data_o);
    if ($countones(bus.req_accept_o) > 1 || (bus.req_accept_o != 4'b0 && !busy)) acc_bad = 1'b1;
    pop = bus.req_valid_i & bus.req_accept_o;
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      if (pop[n]) void'(chq[n].pop_front());
      if (cont[n] && chq[n].size() == 0) chq[n].push_back({1'b1, 16'hC000 | 16'(n)});
    end
    if (toggle) bus.outport_accept_i = ~bus.outport_accept_i;
    drive();
  endtask
  task automatic collect(int n);
    for (int i = 0; i < 300 && outq.size() < n; i++) tick();
  endtask
  task automatic check_stream(string tag, logic [15:0] exp[$]);
    chk({tag, "_len"}, outq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < outq.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(outq[i]), 32'(exp[i]));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    for (int n = 0; n < 4; n++) chq[n].delete();
    cont = 4'b0;
    toggle = 1'b0;
    acc_bad = 1'b0;
    bus.outport_accept_i = 1'b1;
    drive();
    outq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    bus.outport_accept_i = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.outport_valid_o), 0);
    chk("rst_data", 32'(bus.outport_data_o), 0);
    chk("rst_accept", 32'(bus.req_accept_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    // single 3-word packet on ch1
    do_reset();
    chq[1] = '{{1'b0, 16'h1111}, {1'b0, 16'h2222}, {1'b1, 16'h3333}};
    drive();
    collect(5);
    e = '{16'hA100, 16'h1111, 16'h2222, 16'h3333, 16'h5803};
    check_stream("t1", e);
    repeat (3) tick();
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_grant_hold", 32'(grant), 1);
    // all channels requesting one-word packets, ch0 has a second packet
    do_reset();
    chq[0] = '{{1'b1, 16'h0A01}, {1'b1, 16'h0A02}};
    chq[1] = '{{1'b1, 16'h1A01}};
    chq[2] = '{{1'b1, 16'h2A01}};
    chq[3] = '{{1'b1, 16'h3A01}};
    drive();
    collect(15);
`ifdef FT60X_ARB_PRIO_EN
    e = '{16'hA000, 16'h0A01, 16'h5801, 16'hA000, 16'h0A02, 16'h5801, 16'hA100, 16'h1A01, 16'h5801,
          16'hA200, 16'h2A01, 16'h5801, 16'hA300, 16'h3A01, 16'h5801};
`else
    e = '{16'hA000, 16'h0A01, 16'h5801, 16'hA100, 16'h1A01, 16'h5801, 16'hA200, 16'h2A01, 16'h5801,
          16'hA300, 16'h3A01, 16'h5801, 16'hA000, 16'h0A02, 16'h5801};
`endif
    check_stream("t2", e);
    chk("t2_accept_onehot", 32'(acc_bad), 0);
    // 6-word packet on ch2 split by MAX_BURST=4
    do_reset();
    chq[2] = '{{1'b0, 16'h2001}, {1'b0, 16'h2002}, {1'b0, 16'h2003},
               {1'b0, 16'h2004}, {1'b0, 16'h2005}, {1'b1, 16'h2006}};
    drive();
    collect(10);
    e = '{16'hA200, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h5004,
          16'hA200, 16'h2005, 16'h2006, 16'h5802};
    check_stream("t3", e);
    // accept toggling every cycle
    do_reset();
    toggle = 1'b1;
    chq[1] = '{{1'b0, 16'h4441}, {1'b0, 16'h4442}, {1'b1, 16'h4443}};
    drive();
    collect(5);
    e = '{16'hA100, 16'h4441, 16'h4442, 16'h4443, 16'h5803};
    check_stream("t4", e);
    chk("t4_accept_onehot", 32'(acc_bad), 0);
    // ch0 and ch3 requesting continuously
    do_reset();
    cont = 4'b1001;
    chq[0] = '{{1'b1, 16'hC000}};
    chq[3] = '{{1'b1, 16'hC003}};
    drive();
    collect(12);
`ifdef FT60X_ARB_PRIO_EN
    e = '{16'hA000, 16'hC000, 16'h5801, 16'hA000, 16'hC000, 16'h5801,
          16'hA000, 16'hC000, 16'h5801, 16'hA000, 16'hC000, 16'h5801};
`else
    e = '{16'hA000, 16'hC000, 16'h5801, 16'hA300, 16'hC003, 16'h5801,
          16'hA000, 16'hC000, 16'h5801, 16'hA300, 16'hC003, 16'h5801};
`endif
    check_stream("t5", e);
    // reset while ch1 presents its second payload word
    do_reset();
    chq[1] = '{{1'b0, 16'h6001}, {1'b0, 16'h6002}, {1'b0, 16'h6003}, {1'b1, 16'h6004}};
    drive();
    collect(2);
    chk("t6_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.outport_valid_o), 0);
    chk("t6_rst_data", 32'(bus.outport_data_o), 0);
    chk("t6_rst_accept", 32'(bus.req_accept_o), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_grant", 32'(grant), 0);
    chq[1].delete();
    outq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chq[1] = '{{1'b1, 16'h6101}};
    drive();
    collect(3);
    e = '{16'hA100, 16'h6101, 16'h5801};
    check_stream("t6", e);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
